scan_select_sequencer: RTL and testbench
========================================

// Module: scan_select_sequencer
// PURPOSE
//  Upstream driver for the 3x8 one-hot decoder. Generates the 3-bit select and
//  the enable that feed the decoder's y/en inputs. Steps through a masked subset
//  of the 8 channels and holds each one for a programmable dwell time.
//  Supports single-pass and continuous (wrapping) scans with start/stop control.
// PARAMETERS
//  DWELL_W   8   width of dwell count; each channel is held for dwell+1 cycles
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous, active-low reset
//  start      in   1        1-cycle request to begin a scan; honoured only in IDLE
//  stop       in   1        abort the scan; honoured in ACTIVE and IDLE
//  mode       in   1        0 = continuous (wrap), 1 = single pass
//  mask       in   8        channel enables; bit i set = channel i is scanned
//  dwell      in   DWELL_W  hold time per channel, minus 1
//  sel        out  3        channel select to the decoder y input (registered)
//  en         out  1        decoder enable (registered); 1 only while ACTIVE
//  busy       out  1        1 while ACTIVE
//  done       out  1        1-cycle pulse when a single pass completes or start has mask==0
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, sel=0, en=0, busy=0, done=0, dwell counter=0.
//    Reset may assert at any time, including mid-scan. Outputs clear immediately.
//  - States:
//    - IDLE: en=0, busy=0, sel holds its last value.
//    - ACTIVE: en=1, busy=1, sel = current channel.
//  - Leaving IDLE: on an edge with start=1, stop=0 and mask!=0:
//    - mode, mask and dwell are latched into shadow registers.
//    - Next state is ACTIVE with sel = lowest set bit of mask and counter=0.
//    - First en=1 is visible one cycle after start (1-cycle latency).
//  - start=1 with mask==0: stay IDLE and pulse done=1 on the next cycle.
//  - start=1 and stop=1 in the same IDLE cycle: stop wins. No scan starts and done stays 0.
//  - start while ACTIVE is ignored.
//  - Live changes to mask, dwell or mode during ACTIVE have no effect. Only the
//    latched copies are used.
//  - In ACTIVE, the counter increments each cycle. When counter==dwell_latched:
//    - counter clears to 0 and sel advances to the next higher set bit of the latched mask.
//    - Each channel therefore holds for exactly dwell+1 cycles; dwell=0 gives 1 cycle.
//  - End of the ascending order (no higher set bit):
//    - mode=0: wrap to the lowest set bit. This covers 7->0 and also the
//      single-channel mask, where the same channel is re-held indefinitely.
//    - mode=1: next state is IDLE with en=0, busy=0 and done=1 for exactly one cycle.
//      sel keeps the last channel.
//  - stop=1 in ACTIVE: next edge goes to IDLE, en=0, busy=0, done=0. The
//    counter clears. No partial dwell completes.
//  - The next-channel search is a combinational 8-bit priority search on
//    (latched mask & bits above sel). It is not pipelined; sel changes in the
//    same edge as the dwell expiry.
//  - done and en are never 1 in the same cycle. en and busy are always equal.
// TESTING
//  1. mask=8'hFF, dwell=0, mode=1, start pulse -> sel 0,1,...,7 on 8 consecutive
//     cycles with en=1; next cycle en=0, busy=0, done=1 for 1 cycle.
//  2. mask=8'hA4, dwell=2, mode=0 -> sel 2,2,2,5,5,5,7,7,7,2,2,2,... en stays 1
//     and done is never asserted.
//  3. Scan from test 2, then stop=1 while sel=5 -> en=0, busy=0 next cycle,
//     done=0. A subsequent start restarts at sel=2.
//  4. mask=8'h00, start pulse -> en stays 0, done=1 exactly one cycle later.
//     Also: start=1 with stop=1 in IDLE -> no scan and done=0.
//  5. During test 2, drive rst_n=0 asynchronously mid-dwell -> sel=0, en=0,
//     busy=0 before the next edge. After release the block stays IDLE.
//  6. mask=8'h81, dwell=1, mode=1 -> sel 0,0,7,7 then done. Mid-scan,
//     start=1 and mask=8'hFF -> no effect on the sequence.

Source files
------------

// File: rtl/scan_select_sequencer.sv
// Channel scan sequencer driving the select/enable of a 3x8 one-hot decoder.
// Walks the set bits of a latched mask in ascending order, holding each for dwell+1 cycles.
module scan_select_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               en,
  output logic               busy,
  output logic               done
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t               state_q, state_d;
  logic [2:0]           sel_q, sel_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [7:0]           mask_q, mask_d;
  logic                 mode_q, mode_d;
  logic                 done_q, done_d;

  logic [7:0]           above;
  logic [2:0]           first_live, first_latched, next_above;

  // Index of the lowest set bit; the caller separately knows whether any bit is set.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Bits of the latched mask strictly above the current channel; empty when sel is 7.
  assign above         = mask_q & ~((8'd2 << sel_q) - 8'd1);
  assign first_live    = lowest_set(mask);
  assign first_latched = lowest_set(mask_q);
  assign next_above    = lowest_set(above);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          if (mask != 8'h00) begin
            state_d = ACTIVE;
            mask_d  = mask;
            dwell_d = dwell;
            mode_d  = mode;
            sel_d   = first_live;
            cnt_d   = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == dwell_q) begin
          cnt_d = '0;
          if (above != 8'h00) begin
            sel_d = next_above;
          end else if (!mode_q) begin
            sel_d = first_latched;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      cnt_q   <= '0;
      dwell_q <= '0;
      mask_q  <= 8'h00;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  assign sel  = sel_q;
  assign en   = (state_q == ACTIVE);
  assign busy = (state_q == ACTIVE);
  assign done = done_q;

endmodule

// File: tb/tb_scan_select_sequencer.sv
// Directed self-checking bench for scan_select_sequencer.
module tb_scan_select_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] mask = 8'h00;
  logic [7:0] dwell = 8'h00;
  logic [2:0] sel;
  logic       en, busy, done;

  int tests = 0;
  int fails = 0;

  scan_select_sequencer #(.DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .mask(mask), .dwell(dwell), .sel(sel), .en(en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full output check plus the en==busy and never-en-with-done invariants.
  task automatic check_out(input string tag, input logic [2:0] e_sel, input logic e_en,
                           input logic e_done);
    check({tag, ".sel"}, {5'd0, sel}, {5'd0, e_sel});
    check({tag, ".en"}, {7'd0, en}, {7'd0, e_en});
    check({tag, ".busy"}, {7'd0, busy}, {7'd0, e_en});
    check({tag, ".done"}, {7'd0, done}, {7'd0, e_done});
  endtask

  // Outputs are sampled 1 ns after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] seq2 [12] = '{3'd2, 3'd2, 3'd2, 3'd5, 3'd5, 3'd5, 3'd7, 3'd7, 3'd7,
                            3'd2, 3'd2, 3'd2};
  logic [2:0] seq6 [4] = '{3'd0, 3'd0, 3'd7, 3'd7};

  initial begin
    #3;
    check_out("reset", 3'd0, 1'b0, 1'b0);
    #4 rst_n = 1'b1;
    tick();
    check_out("idle_after_reset", 3'd0, 1'b0, 1'b0);

    // Test 1: full mask, dwell 0, single pass.
    mask = 8'hFF; dwell = 8'd0; mode = 1'b1; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      start = 1'b0;
      check_out($sformatf("t1_step%0d", i), 3'(i), 1'b1, 1'b0);
    end
    tick();
    check_out("t1_done", 3'd7, 1'b0, 1'b1);
    tick();
    check_out("t1_done_clear", 3'd7, 1'b0, 1'b0);

    // Test 4: empty mask start, then start with stop.
    mask = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    check_out("t4_empty_done", 3'd7, 1'b0, 1'b1);
    tick();
    check_out("t4_empty_clear", 3'd7, 1'b0, 1'b0);
    mask = 8'hFF; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check_out("t4_start_stop", 3'd7, 1'b0, 1'b0);
    tick();
    check_out("t4_start_stop_after", 3'd7, 1'b0, 1'b0);

    // Test 2: continuous scan of 0xA4 with dwell 2; live inputs changed mid-scan.
    mask = 8'hA4; dwell = 8'd2; mode = 1'b0; start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      start = 1'b0;
      if (i == 1) begin
        mask = 8'hFF; dwell = 8'd0; mode = 1'b1;
      end
      check_out($sformatf("t2_step%0d", i), seq2[i], 1'b1, 1'b0);
    end

    // Test 3: stop while on channel 5, then restart.
    tick();
    check_out("t3_on5", 3'd5, 1'b1, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_out("t3_stopped", 3'd5, 1'b0, 1'b0);
    tick();
    check_out("t3_stays_idle", 3'd5, 1'b0, 1'b0);
    mask = 8'hA4; dwell = 8'd2; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check_out("t3_restart", 3'd2, 1'b1, 1'b0);

    // Test 5: asynchronous reset mid-dwell.
    tick();
    check_out("t5_middwell", 3'd2, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_out("t5_async_reset", 3'd0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    tick();
    check_out("t5_idle1", 3'd0, 1'b0, 1'b0);
    tick();
    check_out("t5_idle2", 3'd0, 1'b0, 1'b0);

    // Test 6: mask 0x81, dwell 1, single pass; start/mask poked mid-scan.
    mask = 8'h81; dwell = 8'd1; mode = 1'b1; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      start = (i == 0);
      if (i == 0) begin
        mask = 8'hFF; dwell = 8'd0; mode = 1'b0;
      end else begin
        mask = 8'h81;
      end
      check_out($sformatf("t6_step%0d", i), seq6[i], 1'b1, 1'b0);
    end
    start = 1'b0;
    tick();
    check_out("t6_done", 3'd7, 1'b0, 1'b1);
    tick();
    check_out("t6_done_clear", 3'd7, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
